// File: rtl/if_stage.sv
// Instruction fetch stage: pre-IF next-PC selection, IF stage register and instruction SRAM port.
// Optional one-entry instruction buffer enabled by defining IF_INST_BUF_EN.
module if_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic [33:0] br_bus,
  output logic        fs_to_ds_valid,
  output logic [63:0] fs_to_ds_bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  localparam logic [31:0] ResetPc = 32'h1BFF_FFFC;

  logic        br_stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        br_fire;

  logic        to_fs_valid;
  logic        fs_ready_go;
  logic        fs_allowin;
  logic        fetch_go;
  logic [31:0] nextpc;
  logic [31:0] fs_inst;

  logic        fs_valid_q, fs_valid_d;
  logic [31:0] fs_pc_q, fs_pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;

  assign br_stall  = br_bus[33];
  assign br_taken  = br_bus[32];
  assign br_target = br_bus[31:0];

  // A branch redirects only in the cycle decode hands it on.
  assign br_fire     = br_taken & ds_allowin;
  assign to_fs_valid = ~reset;
  assign fs_ready_go = ~br_stall;
  assign fs_allowin  = ~fs_valid_q | (fs_ready_go & ds_allowin);
  assign fetch_go    = to_fs_valid & fs_allowin;

  always_comb begin
    if (br_fire) begin
      nextpc = br_target;
    end else if (pend_valid_q) begin
      nextpc = pend_target_q;
    end else begin
      nextpc = fs_pc_q + 32'd4;
    end
  end

  always_comb begin
    fs_valid_d    = fs_valid_q;
    fs_pc_d       = fs_pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    if (fs_allowin) begin
      fs_valid_d = to_fs_valid;
    end
    if (fetch_go) begin
      fs_pc_d = nextpc;
    end
    // A redirect that cannot fetch now is remembered until the next fetch.
    if (br_fire && !fetch_go) begin
      pend_valid_d  = 1'b1;
      pend_target_d = br_target;
    end else if (fetch_go) begin
      pend_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid_q    <= 1'b0;
      fs_pc_q       <= ResetPc;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'h0;
    end else begin
      fs_valid_q    <= fs_valid_d;
      fs_pc_q       <= fs_pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

`ifdef IF_INST_BUF_EN
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_inst_q, buf_inst_d;

  // Capture the fresh read data the first cycle the instruction cannot leave.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_inst_d  = buf_inst_q;
    if (fs_to_ds_valid && ds_allowin) begin
      buf_valid_d = 1'b0;
    end else if (fs_valid_q && !buf_valid_q && !(fs_ready_go && ds_allowin)) begin
      buf_valid_d = 1'b1;
      buf_inst_d  = inst_sram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid_q <= 1'b0;
      buf_inst_q  <= 32'h0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_inst_q  <= buf_inst_d;
    end
  end

  assign fs_inst = buf_valid_q ? buf_inst_q : inst_sram_rdata;
`else
  // The SRAM keeps its read data while inst_sram_en is low.
  assign fs_inst = inst_sram_rdata;
`endif

  assign inst_sram_en    = fetch_go;
  assign inst_sram_we    = 4'h0;
  assign inst_sram_wdata = 32'h0;
  assign inst_sram_addr  = reset ? 32'h0 : nextpc;
  assign fs_to_ds_valid  = ~reset & fs_valid_q & fs_ready_go;
  assign fs_to_ds_bus    = reset ? 64'h0 : {fs_pc_q, fs_inst};

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed address checks plus a scoreboard of
// {pc, inst} pairs that decode must receive, in order.
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        ds_allowin;
  logic [33:0] br_bus;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  int          n_tests;
  int          n_fail;
  logic [63:0] sb_q[$];
  logic        corrupt;
  logic        seen_0c;

  if_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ds_allowin      (ds_allowin),
    .br_bus          (br_bus),
    .fs_to_ds_valid  (fs_to_ds_valid),
    .fs_to_ds_bus    (fs_to_ds_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // SRAM model: one-cycle read latency, output held while not enabled.
  always @(posedge clk) begin
    if (inst_sram_en) begin
      inst_sram_rdata <= inst_of(inst_sram_addr);
      if (inst_sram_addr == 32'h1C00_000C) seen_0c <= 1'b1;
    end else if (corrupt) begin
      inst_sram_rdata <= 32'hDEAD_BEEF;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc);
    sb_q.push_back({pc, inst_of(pc)});
  endtask

  // Drive one cycle's inputs away from the active edge, then score any handshake.
  task automatic drive(input logic rst, input logic alw, input logic stall,
                       input logic taken, input logic [31:0] tgt);
    logic [63:0] exp;
    @(negedge clk);
    reset      = rst;
    ds_allowin = alw;
    br_bus     = {stall, taken, tgt};
    #1;
    if (!reset && fs_to_ds_valid && ds_allowin) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected", 64'(sb_q.size() == 0), 64'd0);
      end else begin
        exp = sb_q.pop_front();
        check("sb_bus", fs_to_ds_bus, exp);
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    corrupt    = 1'b0;
    seen_0c    = 1'b0;
    reset      = 1'b1;
    ds_allowin = 1'b0;
    br_bus     = '0;

    // Reset state
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check("rst_en", inst_sram_en, 0);
    check("rst_valid", fs_to_ds_valid, 0);
    check("rst_bus", fs_to_ds_bus, 0);
    check("rst_addr", inst_sram_addr, 0);
    check("rst_we", inst_sram_we, 0);
    check("rst_wdata", inst_sram_wdata, 0);

    // Sequential fetch, then a taken branch out of 1C000008
    push(32'h1C00_0000); push(32'h1C00_0004); push(32'h1C00_0008);
    push(32'h1C00_0100); push(32'h1C00_0104);
    run(1);
    check("first_addr", inst_sram_addr, 32'h1C00_0000);
    check("first_en", inst_sram_en, 1);
    check("first_valid", fs_to_ds_valid, 0);
    run(1);
    check("seq_addr1", inst_sram_addr, 32'h1C00_0004);
    run(1);
    check("seq_addr2", inst_sram_addr, 32'h1C00_0008);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h1C00_0100);
    check("br_addr", inst_sram_addr, 32'h1C00_0100);
    run(1);
    check("br_addr_next", inst_sram_addr, 32'h1C00_0104);
    check("br_fs_pc", fs_to_ds_bus[63:32], 32'h1C00_0100);
    run(1);
    check("no_fetch_0c", seen_0c, 0);

    // Decode back-pressure for 3 cycles with fs_pc=1C000010
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    push(32'h1C00_0000); push(32'h1C00_0004); push(32'h1C00_0008);
    push(32'h1C00_000C); push(32'h1C00_0010); push(32'h1C00_0014);
    run(1);
    check("restart_addr", inst_sram_addr, 32'h1C00_0000);
    run(4);
`ifdef IF_INST_BUF_EN
    corrupt = 1'b1;
`endif
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      check("hold_en", inst_sram_en, 0);
      check("hold_bus", fs_to_ds_bus, {32'h1C00_0010, inst_of(32'h1C00_0010)});
    end
    corrupt = 1'b0;
    run(1);
    check("resume_addr", inst_sram_addr, 32'h1C00_0014);
    run(1);

    // br_stall for 2 cycles with fs_pc=1C000018
    push(32'h1C00_0018); push(32'h1C00_001C);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      check("stall_valid", fs_to_ds_valid, 0);
      check("stall_en", inst_sram_en, 0);
      check("stall_pc", fs_to_ds_bus[63:32], 32'h1C00_0018);
    end
    run(1);
    check("unstall_addr", inst_sram_addr, 32'h1C00_001C);
    run(1);
    check("unstall_addr2", inst_sram_addr, 32'h1C00_0020);

    // Branch while stalled: redirect is held pending
    push(32'h1C00_0020); push(32'h1C00_0200);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h1C00_0200);
    check("pend_en", inst_sram_en, 0);
    run(1);
    check("pend_addr", inst_sram_addr, 32'h1C00_0200);
    run(1);
    check("pend_clear_addr", inst_sram_addr, 32'h1C00_0204);

    // Reset with a redirect pending, then wrap at the top of the address space
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h1C00_0300);
    check("pend2_en", inst_sram_en, 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check("rst2_en", inst_sram_en, 0);
    check("rst2_valid", fs_to_ds_valid, 0);
    push(32'h1C00_0000); push(32'hFFFF_FFFC); push(32'h0000_0000);
    run(1);
    check("rst_pend_addr", inst_sram_addr, 32'h1C00_0000);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    check("top_addr", inst_sram_addr, 32'hFFFF_FFFC);
    run(1);
    check("wrap_addr", inst_sram_addr, 32'h0000_0000);
    run(1);
    check("wrap_addr_next", inst_sram_addr, 32'h0000_0004);

    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
